// File: rtl/ahb_bus_arbiter.sv
// Three-way AHB master-port arbiter (TLB, L1, external master) with a one-cycle handover gap and an advisory yield request to a long-holding external master.
// Build option: define ARB_RR_EN for round-robin selection; fixed priority req[0] > req[1] > req[2] otherwise.
module ahb_bus_arbiter #(
  parameter int EXT_MAX_HOLD = 256,
  parameter int HOLD_W       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] ack,
  output logic [1:0] owner,
  output logic       bus_busy,
  input  logic [1:0] htrans_cur,
  input  logic       hmastlock_cur,
  input  logic       hready,
  output logic       ext_yield_req
);

  localparam logic [1:0]        ST_IDLE    = 2'd0;
  localparam logic [1:0]        ST_GRANT   = 2'd1;
  localparam logic [1:0]        ST_GAP     = 2'd2;
  localparam logic [1:0]        OWNER_NONE = 2'd3;
  localparam logic [1:0]        HTRANS_IDLE = 2'b00;
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(EXT_MAX_HOLD);

  logic [1:0]        state_q, state_d;
  logic [2:0]        ack_q, ack_d;
  logic [1:0]        owner_q, owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              ext_yield_q, ext_yield_d;
  logic [1:0]        winner;
  logic              release_ok;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

`ifdef ARB_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] cand;

  always_comb begin
    winner = OWNER_NONE;
    cand   = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (winner == OWNER_NONE && req[cand]) winner = cand;
      cand = next_idx(cand);
    end
  end

  assign rr_ptr_d = (state_q == ST_IDLE && |req) ? next_idx(winner) : rr_ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= 2'd0;
    else      rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    if (req[0])      winner = 2'd0;
    else if (req[1]) winner = 2'd1;
    else if (req[2]) winner = 2'd2;
    else             winner = OWNER_NONE;
  end
`endif

  // The owner may only let go once it has dropped req and the bus is quiet and unlocked.
  assign release_ok = !(|(req & ack_q)) && !hmastlock_cur && hready && (htrans_cur == HTRANS_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    ext_yield_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          ack_d   = 3'b001 << winner;
          owner_d = winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_ok) begin
          ack_d      = 3'b000;
          owner_d    = OWNER_NONE;
          hold_cnt_d = '0;
          state_d    = ST_GAP;
        end else if (owner_q == 2'd2) begin
          hold_cnt_d  = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
          ext_yield_d = (hold_cnt_q >= HOLD_LIMIT) && (req[0] | req[1]);
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        state_d    = ST_IDLE;
        ack_d      = 3'b000;
        owner_d    = OWNER_NONE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ack_q       <= 3'b000;
      owner_q     <= OWNER_NONE;
      hold_cnt_q  <= '0;
      ext_yield_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      ext_yield_q <= ext_yield_d;
    end
  end

  assign ack           = ack_q;
  assign owner         = owner_q;
  assign bus_busy      = |ack_q;
  assign ext_yield_req = ext_yield_q;

  ack_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(ack_q));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a behavioural model.
module tb_ahb_bus_arbiter;

  localparam int TB_MAX_HOLD = 4;
  localparam int TB_HOLD_W   = 3;
  localparam int HOLD_SAT    = (1 << TB_HOLD_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req_i = '0;
  logic [1:0] htrans_i = '0;
  logic       lock_i = 1'b0;
  logic       hready_i = 1'b1;
  logic [2:0] ack;
  logic [1:0] owner;
  logic       bus_busy;
  logic       ext_yield_req;

  int checks = 0;
  int failures = 0;

  ahb_bus_arbiter #(.EXT_MAX_HOLD(TB_MAX_HOLD), .HOLD_W(TB_HOLD_W)) dut (
    .clk(clk), .rst(rst), .req(req_i), .ack(ack), .owner(owner), .bus_busy(bus_busy),
    .htrans_cur(htrans_i), .hmastlock_cur(lock_i), .hready(hready_i), .ext_yield_req(ext_yield_req)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the bus, whether we're in the turnaround gap, how long ext has held.
  int m_owner = 3;
  bit m_gap   = 0;
  int m_hold  = 0;
  bit m_yield = 0;
  int m_rr    = 0;

  task automatic model_reset();
    m_owner = 3; m_gap = 0; m_hold = 0; m_yield = 0; m_rr = 0;
  endtask

  task automatic model_step();
    bit yield_n = 0;
    if (m_owner != 3) begin
      if (!req_i[m_owner] && !lock_i && hready_i && htrans_i == 2'b00) begin
        m_owner = 3; m_gap = 1; m_hold = 0;
      end else if (m_owner == 2) begin
        yield_n = (m_hold >= TB_MAX_HOLD) && (req_i[0] || req_i[1]);
        if (m_hold < HOLD_SAT) m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (req_i != 3'b000) begin
      for (int k = 0; k < 3; k++) begin
`ifdef ARB_RR_EN
        int idx = (m_rr + k) % 3;
`else
        int idx = k;
`endif
        if (m_owner == 3 && req_i[idx]) begin
          m_owner = idx;
          m_rr = (idx + 1) % 3;
        end
      end
    end
    m_yield = yield_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_ack, input logic [1:0] e_owner,
                            input logic e_yield);
    check({tag, ".ack"}, 32'(ack), 32'(e_ack));
    check({tag, ".owner"}, 32'(owner), 32'(e_owner));
    check({tag, ".bus_busy"}, 32'(bus_busy), 32'(|e_ack));
    check({tag, ".ext_yield_req"}, 32'(ext_yield_req), 32'(e_yield));
  endtask

  typedef struct {
    logic [2:0] req;
    logic [1:0] htrans;
    logic       lock;
    logic       hready;
    logic [2:0] exp_ack;
    logic [1:0] exp_owner;
  } vec_t;

  vec_t vecs[17];
  int   exp_seq[4];

  initial begin
    // Handover with gap, release held by in-flight transfer, release held by lock.
    vecs[0]  = '{3'b011, 2'b00, 1'b0, 1'b1, 3'b001, 2'd0};
    vecs[1]  = '{3'b011, 2'b00, 1'b0, 1'b1, 3'b001, 2'd0};
    vecs[2]  = '{3'b010, 2'b00, 1'b0, 1'b1, 3'b000, 2'd3};
    vecs[3]  = '{3'b010, 2'b00, 1'b0, 1'b1, 3'b000, 2'd3};
    vecs[4]  = '{3'b010, 2'b00, 1'b0, 1'b1, 3'b010, 2'd1};
    vecs[5]  = '{3'b000, 2'b10, 1'b0, 1'b0, 3'b010, 2'd1};
    vecs[6]  = '{3'b000, 2'b10, 1'b0, 1'b0, 3'b010, 2'd1};
    vecs[7]  = '{3'b000, 2'b10, 1'b0, 1'b0, 3'b010, 2'd1};
    vecs[8]  = '{3'b000, 2'b10, 1'b0, 1'b1, 3'b010, 2'd1};
    vecs[9]  = '{3'b000, 2'b00, 1'b0, 1'b1, 3'b000, 2'd3};
    vecs[10] = '{3'b010, 2'b00, 1'b0, 1'b1, 3'b000, 2'd3};
    vecs[11] = '{3'b010, 2'b00, 1'b0, 1'b1, 3'b010, 2'd1};
    vecs[12] = '{3'b000, 2'b00, 1'b1, 1'b1, 3'b010, 2'd1};
    vecs[13] = '{3'b000, 2'b00, 1'b1, 1'b1, 3'b010, 2'd1};
    vecs[14] = '{3'b000, 2'b00, 1'b0, 1'b1, 3'b000, 2'd3};
    vecs[15] = '{3'b000, 2'b00, 1'b0, 1'b1, 3'b000, 2'd3};
    vecs[16] = '{3'b000, 2'b00, 1'b0, 1'b1, 3'b000, 2'd3};
`ifdef ARB_RR_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("in_reset", 3'b000, 2'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Idle bus after reset release.
    for (int c = 0; c < 10; c++) begin
      tick();
      check_outs($sformatf("idle_c%0d", c), 3'b000, 2'd3, 1'b0);
    end

    for (int i = 0; i < 17; i++) begin
      req_i = vecs[i].req; htrans_i = vecs[i].htrans; lock_i = vecs[i].lock; hready_i = vecs[i].hready;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_owner, 1'b0);
    end
    htrans_i = 2'b00; lock_i = 1'b0; hready_i = 1'b1;

    // Long external hold: yield from cycle 5, saturating counter keeps it high, ack never revoked.
    req_i = 3'b100;
    tick();
    check_outs("ext_c0", 3'b100, 2'd2, 1'b0);
    for (int c = 0; c < 10; c++) begin
      req_i = {1'b1, 1'b0, (c >= 2)};
      tick();
      check_outs($sformatf("ext_c%0d", c + 1), 3'b100, 2'd2, (c + 1 >= 5));
    end
    req_i = 3'b001;
    tick();
    check_outs("ext_release", 3'b000, 2'd3, 1'b0);
    tick();
    check_outs("ext_gap", 3'b000, 2'd3, 1'b0);
    tick();
    check_outs("ext_then_tlb", 3'b001, 2'd0, 1'b0);
    req_i = 3'b000;
    repeat (3) tick();
    check_outs("ext_done", 3'b000, 2'd3, 1'b0);

    // Asynchronous reset in the middle of a grant.
    req_i = 3'b010;
    tick();
    check_outs("pre_reset_grant", 3'b010, 2'd1, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_outs("async_reset", 3'b000, 2'd3, 1'b0);
    req_i = 3'b000;
    @(negedge clk);
    rst = 1'b1;

    // All three requesting; each owner drops briefly to release, then re-requests.
    req_i = 3'b111;
    tick();
    check_outs("arb_g0", 3'(1 << exp_seq[0]), 2'(exp_seq[0]), 1'b0);
    for (int g = 1; g < 4; g++) begin
      req_i = 3'b111 & ~(3'b001 << exp_seq[g-1]);
      tick();
      check_outs($sformatf("arb_rel%0d", g), 3'b000, 2'd3, 1'b0);
      req_i = 3'b111;
      tick();
      check_outs($sformatf("arb_gap%0d", g), 3'b000, 2'd3, 1'b0);
      tick();
      check_outs($sformatf("arb_g%0d", g), 3'(1 << exp_seq[g]), 2'(exp_seq[g]), 1'b0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(7) == 0) req_i[b] = ~req_i[b];
      htrans_i = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom_range(3));
      hready_i = ($urandom_range(3) != 0);
      lock_i   = ($urandom_range(7) == 0);
      tick();
      check_outs($sformatf("rand_c%0d", c), (m_owner == 3) ? 3'b000 : 3'(1 << m_owner),
                 2'(m_owner), m_yield);
      check($sformatf("rand_onehot_c%0d", c), 32'($onehot0(ack)), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
